sipo_frame_ctrl: RTL

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

---
 rtl/sipo_frame_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: serial-in/parallel-out frame receiver.
// Accepts start / WIDTH data / optional even parity / stop frames, one bit per
// bit_en strobe, and holds each good word for a ready/valid consumer.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             sin,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               par_bad_q, par_bad_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;

  logic               handshake;
  logic               frame_good;

  assign handshake  = out_valid_q & out_ready;
  // Parity is ignored entirely when the frame carries no parity bit.
  assign frame_good = sin & ~(PARITY_EN & par_bad_q);

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, frame sequencing and output-holding decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // A consumer handshake frees the holding register unless refilled below.
    if (handshake) begin
      out_valid_d = 1'b0;
    end

    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          shift_d = {shift_q[WIDTH-2:0], sin};
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          par_bad_d = (^shift_q) ^ sin;
          state_d   = STOP;
        end
        STOP: begin
          state_d   = IDLE;
          par_bad_d = 1'b0;
          if (!frame_good) begin
            frame_err_d = 1'b1;
          end else if (!out_valid_q || out_ready) begin
            data_d      = shift_q;
            out_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign data      = data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
